// File: rtl/branch_pred_ctrl_pkg.sv
// Shared types and defaults for the branch predictor controller slice.
package lab4_branch_pkg;

  localparam int unsigned DEFAULT_NUM_INFLIGHT = 4;
  localparam int unsigned DEFAULT_PC_W         = 32;

  typedef struct packed {
    logic [DEFAULT_PC_W-1:0] pc;
    logic                    pred;
  } inflight_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/branch_pred_ctrl_if.sv
// Fetch/execute/predictor signal bundle; master is the environment, slave is the controller.
interface branch_pred_ctrl_if #(
  parameter int unsigned NUM_INFLIGHT = 4,
  parameter int unsigned PC_W         = 32
);
  logic                          req_val;
  logic                          req_rdy;
  logic [PC_W-1:0]               req_pc;
  logic                          resp_taken;
  logic                          resolve_val;
  logic                          resolve_rdy;
  logic                          resolve_taken;
  logic                          mispredict;
  logic [PC_W-1:0]               pred_pc;
  logic                          pred_update_en;
  logic                          pred_update_val;
  logic                          pred_prediction;
  logic [$clog2(NUM_INFLIGHT):0] inflight_count;

  modport master (
    output req_val, req_pc, resolve_val, resolve_taken, pred_prediction,
    input  req_rdy, resp_taken, resolve_rdy, mispredict, pred_pc,
           pred_update_en, pred_update_val, inflight_count
  );

  modport slave (
    input  req_val, req_pc, resolve_val, resolve_taken, pred_prediction,
    output req_rdy, resp_taken, resolve_rdy, mispredict, pred_pc,
           pred_update_en, pred_update_val, inflight_count
  );
endinterface

// File: rtl/branch_pred_ctrl_inflight_fifo.sv
// Circular FIFO of in-flight branches with push/pop/flush and occupancy count.
module branch_inflight_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 33
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [DW-1:0]          wdata_i,
  output logic [DW-1:0]          rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/branch_pred_ctrl.sv
// Shares one bimodal predictor between fetch and in-order resolve; flags mispredicts.
// Optional statistics counters when BRANCH_PRED_CTRL_STATS_EN is defined.
module branch_pred_ctrl
  import lab4_branch_pkg::*;
#(
  parameter int unsigned NUM_INFLIGHT = DEFAULT_NUM_INFLIGHT,
  parameter int unsigned PC_W         = DEFAULT_PC_W
) (
  input  logic              clk,
  input  logic              reset,
  branch_pred_ctrl_if.slave bp
`ifdef BRANCH_PRED_CTRL_STATS_EN
  ,
  output logic [31:0]       stat_resolved,
  output logic [31:0]       stat_mispred
`endif
);
  ctrl_state_t   state_q, state_d;
  logic          mispredict_q, mispredict_d;
  logic [PC_W:0] head;
  logic [$clog2(NUM_INFLIGHT):0] count;
  logic          full, empty;
  logic          resolve_rdy, req_rdy, flush;
  logic          resolve_fire, req_fire;

  branch_inflight_fifo #(
    .DEPTH (NUM_INFLIGHT),
    .DW    (PC_W + 1)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (req_fire),
    .pop_i   (resolve_fire),
    .flush_i (flush),
    .wdata_i ({bp.req_pc, bp.pred_prediction}),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (mispredict_d) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Resolve owns the predictor port, so a pending request is held off this cycle.
  always_comb begin
    resolve_rdy = (state_q == RUN) && !empty;
    req_rdy     = (state_q == RUN) && !full && !(bp.resolve_val && resolve_rdy);
    flush       = (state_q == FLUSH);
  end

  assign resolve_fire = bp.resolve_val && resolve_rdy;
  assign req_fire     = bp.req_val && req_rdy;
  assign mispredict_d = resolve_fire && (bp.resolve_taken != head[0]);

  always_ff @(posedge clk) begin
    if (reset) mispredict_q <= 1'b0;
    else       mispredict_q <= mispredict_d;
  end

  assign bp.resolve_rdy     = resolve_rdy;
  assign bp.req_rdy         = req_rdy;
  assign bp.pred_pc         = resolve_fire ? head[PC_W:1] : bp.req_pc;
  assign bp.pred_update_en  = resolve_fire;
  assign bp.pred_update_val = resolve_fire && bp.resolve_taken;
  assign bp.resp_taken      = req_fire && bp.pred_prediction;
  assign bp.mispredict      = mispredict_q;
  assign bp.inflight_count  = count;

`ifdef BRANCH_PRED_CTRL_STATS_EN
  logic [31:0] stat_resolved_q, stat_mispred_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (resolve_fire) stat_resolved_q <= stat_resolved_q + 32'd1;
      if (mispredict_d) stat_mispred_q  <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`endif
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl with a queue-based reference model.
module tb_branch_pred_ctrl;
  import lab4_branch_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned PC_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic pmode;
  always #5 clk = ~clk;

  branch_pred_ctrl_if #(.NUM_INFLIGHT(N), .PC_W(PC_W)) bif ();

  // Predictor stand-in: always taken, or taken when pc[2] is set.
  assign bif.pred_prediction = pmode ? bif.pred_pc[2] : 1'b1;

`ifdef BRANCH_PRED_CTRL_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif

  branch_pred_ctrl #(.NUM_INFLIGHT(N), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bif)
`ifdef BRANCH_PRED_CTRL_STATS_EN
    ,
    .stat_resolved (stat_resolved),
    .stat_mispred  (stat_mispred)
`endif
  );

  inflight_entry_t mq[$];
  bit              m_flush, m_mis, m_valid;
  int unsigned     m_res, m_mp;
  int              n_vec, n_err;

  typedef struct {
    bit          rq;
    logic [31:0] pc;
    bit          rs;
    bit          tk;
  } vec_t;

  function automatic bit pf(logic [31:0] pc);
    return pmode ? pc[2] : 1'b1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    bif.req_val       = 1'b0;
    bif.resolve_val   = 1'b0;
    bif.resolve_taken = 1'b0;
    bif.req_pc        = 32'hDEAD_0000;
  endtask

  task automatic drive(bit rq, logic [31:0] pc, bit rs, bit tk);
    bif.req_val       = rq;
    bif.req_pc        = pc;
    bif.resolve_val   = rs;
    bif.resolve_taken = tk;
  endtask

  // Compare all outputs against the model at the falling edge.
  task automatic sample();
    bit rr, rf, qr, qf;
    @(negedge clk);
    if (m_valid && !reset) begin
      rr = !m_flush && (mq.size() > 0);
      rf = bif.resolve_val && rr;
      qr = !m_flush && (mq.size() < int'(N)) && !rf;
      qf = bif.req_val && qr;
      chk("resolve_rdy", 32'(bif.resolve_rdy), 32'(rr));
      chk("req_rdy", 32'(bif.req_rdy), 32'(qr));
      chk("pred_pc", bif.pred_pc, rf ? mq[0].pc : bif.req_pc);
      chk("pred_update_en", 32'(bif.pred_update_en), 32'(rf));
      if (rf) chk("pred_update_val", 32'(bif.pred_update_val), 32'(bif.resolve_taken));
      chk("resp_taken", 32'(bif.resp_taken), qf ? 32'(pf(bif.req_pc)) : 32'd0);
      chk("inflight_count", 32'(bif.inflight_count), 32'(mq.size()));
      chk("mispredict", 32'(bif.mispredict), 32'(m_mis));
`ifdef BRANCH_PRED_CTRL_STATS_EN
      chk("stat_resolved", stat_resolved, m_res);
      chk("stat_mispred", stat_mispred, m_mp);
`endif
    end
  endtask

  task automatic advance();
    bit rr, rf, qr, qf;
    inflight_entry_t e;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_flush = 0; m_mis = 0; m_res = 0; m_mp = 0; m_valid = 1;
    end else if (m_flush) begin
      mq.delete();
      m_flush = 0; m_mis = 0;
    end else begin
      rr = mq.size() > 0;
      rf = bif.resolve_val && rr;
      qr = (mq.size() < int'(N)) && !rf;
      qf = bif.req_val && qr;
      if (rf) begin
        e = mq.pop_front();
        m_res++;
        if (bif.resolve_taken != e.pred) begin
          m_flush = 1; m_mis = 1; m_mp++;
        end
      end
      if (qf) begin
        e.pc = bif.req_pc;
        e.pred = pf(bif.req_pc);
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  vec_t tbl[9];

  initial begin
    n_vec = 0; n_err = 0; m_valid = 0;
    pmode = 1'b0;
    reset = 1'b1;
    idle();
    advance();
    advance();
    reset = 1'b0;

    // Reset state
    sample();
    chk("rst_count", 32'(bif.inflight_count), 32'd0);
    chk("rst_req_rdy", 32'(bif.req_rdy), 32'd1);
    chk("rst_resolve_rdy", 32'(bif.resolve_rdy), 32'd0);
    chk("rst_upd_en", 32'(bif.pred_update_en), 32'd0);
    chk("rst_mispredict", 32'(bif.mispredict), 32'd0);
    advance();

    // First request
    drive(1, 32'h100, 0, 0);
    sample();
    chk("t1_req_rdy", 32'(bif.req_rdy), 32'd1);
    chk("t1_resp_taken", 32'(bif.resp_taken), 32'd1);
    chk("t1_upd_en", 32'(bif.pred_update_en), 32'd0);
    advance();
    idle();
    sample();
    chk("t1_count", 32'(bif.inflight_count), 32'd1);
    advance();

    // Fill to full, then resolve all correctly in order
    for (int i = 1; i < 4; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 0, 0);
      step();
    end
    drive(1, 32'h110, 0, 0);
    sample();
    chk("full_count", 32'(bif.inflight_count), 32'd4);
    chk("full_req_rdy", 32'(bif.req_rdy), 32'd0);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 1, 1);
      sample();
      chk("res_pred_pc", bif.pred_pc, 32'h100 + 32'(4 * i));
      chk("res_upd_en", 32'(bif.pred_update_en), 32'd1);
      advance();
    end
    idle();
    sample();
    chk("drain_count", 32'(bif.inflight_count), 32'd0);
    chk("drain_mispredict", 32'(bif.mispredict), 32'd0);
    advance();

    // Request collides with resolve; request stalls and fires next cycle
    drive(1, 32'h100, 0, 0);
    step();
    drive(1, 32'h200, 1, 1);
    sample();
    chk("coll_pred_pc", bif.pred_pc, 32'h100);
    chk("coll_req_rdy", 32'(bif.req_rdy), 32'd0);
    advance();
    drive(1, 32'h200, 0, 0);
    sample();
    chk("stall_pred_pc", bif.pred_pc, 32'h200);
    chk("stall_req_rdy", 32'(bif.req_rdy), 32'd1);
    advance();
    drive(0, 32'h0, 1, 1);
    sample();
    chk("stall_head", bif.pred_pc, 32'h200);
    advance();

    // Mispredict with three entries
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(4 * i), 0, 0);
      step();
    end
    drive(0, 32'h0, 1, 0);
    sample();
    chk("mp_upd_val", 32'(bif.pred_update_val), 32'd0);
    advance();
    drive(1, 32'h400, 0, 0);
    sample();
    chk("fl_mispredict", 32'(bif.mispredict), 32'd1);
    chk("fl_req_rdy", 32'(bif.req_rdy), 32'd0);
    chk("fl_resolve_rdy", 32'(bif.resolve_rdy), 32'd0);
    chk("fl_count", 32'(bif.inflight_count), 32'd2);
    advance();
    sample();
    chk("post_count", 32'(bif.inflight_count), 32'd0);
    chk("post_mispredict", 32'(bif.mispredict), 32'd0);
    chk("post_req_rdy", 32'(bif.req_rdy), 32'd1);
    advance();
    drive(0, 32'h0, 1, 1);
    step();

    // Resolve on empty FIFO is ignored
    drive(0, 32'h0, 1, 1);
    sample();
    chk("empty_resolve_rdy", 32'(bif.resolve_rdy), 32'd0);
    chk("empty_upd_en", 32'(bif.pred_update_en), 32'd0);
    advance();
    sample();
    chk("empty_count", 32'(bif.inflight_count), 32'd0);
    advance();
    idle();

    // Address-dependent predictions, full FIFO with concurrent traffic
    pmode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h500 + 32'(4 * i), 0, 0);
      step();
    end
    tbl[0] = '{1, 32'h510, 1, 0};
    tbl[1] = '{1, 32'h510, 0, 0};
    tbl[2] = '{1, 32'h514, 1, 1};
    tbl[3] = '{1, 32'h514, 1, 1};
    tbl[4] = '{1, 32'h514, 0, 0};
    tbl[5] = '{1, 32'h514, 0, 0};
    tbl[6] = '{0, 32'h0, 1, 0};
    tbl[7] = '{0, 32'h0, 1, 1};
    tbl[8] = '{0, 32'h0, 1, 1};
    foreach (tbl[i]) begin
      drive(tbl[i].rq, tbl[i].pc, tbl[i].rs, tbl[i].tk);
      sample();
      if (i == 0) begin
        chk("full_res_req_rdy", 32'(bif.req_rdy), 32'd0);
        chk("full_res_upd_en", 32'(bif.pred_update_en), 32'd1);
      end
      advance();
    end
    idle();

    // Reset during the flush cycle
    pmode = 1'b0;
    drive(1, 32'h600, 0, 0); step();
    drive(1, 32'h604, 0, 0); step();
    drive(0, 32'h0, 1, 0); step();
    idle();
    reset = 1'b1;
    sample();
    advance();
    reset = 1'b0;
    sample();
    chk("rfl_count", 32'(bif.inflight_count), 32'd0);
    chk("rfl_mispredict", 32'(bif.mispredict), 32'd0);
    chk("rfl_req_rdy", 32'(bif.req_rdy), 32'd1);
`ifdef BRANCH_PRED_CTRL_STATS_EN
    chk("rfl_stat_resolved", stat_resolved, 32'd0);
    chk("rfl_stat_mispred", stat_mispred, 32'd0);
`endif
    advance();

    // Reset with a full FIFO
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h700 + 32'(4 * i), 0, 0);
      step();
    end
    idle();
    reset = 1'b1;
    advance();
    reset = 1'b0;
    sample();
    chk("rfull_count", 32'(bif.inflight_count), 32'd0);
    chk("rfull_resolve_rdy", 32'(bif.resolve_rdy), 32'd0);
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/branch_pred_ctrl.md
Name: branch_pred_ctrl

Overview:
- Controller that shares one bimodal predictor (single PC port, update_en/update_val, combinational prediction) between two requesters.
- The fetch stage asks for predictions. The execute stage resolves branches in order.
- The block tracks in-flight predicted branches in a FIFO, arbitrates the predictor's PC port, issues training updates, and flags mispredictions.
- The flag triggers a one-cycle flush of younger in-flight branches.

Parameters:
- NUM_INFLIGHT, 4, depth of the in-flight branch FIFO; power of two, minimum 2.
- PC_W, 32, PC width; must match the predictor PC port.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_val  in  1  fetch prediction request valid
- req_rdy  out  1  fetch request accepted when req_val && req_rdy
- req_pc  in  PC_W  branch PC to predict
- resp_taken  out  1  prediction for the accepted request; valid in the same cycle as the request fire
- resolve_val  in  1  execute resolves the oldest in-flight branch
- resolve_rdy  out  1  resolve accepted when resolve_val && resolve_rdy
- resolve_taken  in  1  actual branch outcome
- mispredict  out  1  registered; high the cycle after a resolve whose outcome differs from its stored prediction
- pred_pc  out  PC_W  PC driven to the predictor
- pred_update_en  out  1  predictor training enable
- pred_update_val  out  1  predictor training outcome
- pred_prediction  in  1  predictor combinational prediction for pred_pc
- inflight_count  out  $clog2(NUM_INFLIGHT)+1  number of FIFO occupants

Behaviour:
- Reset values:
  - FIFO empty; inflight_count=0; mispredict=0; state RUN.
  - All combinational outputs follow from the empty FIFO: req_rdy=1, resolve_rdy=0, pred_update_en=0.
- FIFO entries hold {pc, predicted_taken}. Read/write pointers wrap modulo NUM_INFLIGHT. A separate count distinguishes full from empty.
- States:
  - RUN: normal operation.
  - FLUSH: entered the cycle after a mispredicting resolve; lasts exactly 1 cycle; then returns to RUN.
- Predictor PC-port arbitration (combinational):
  - Resolve fires (resolve_val && count>0 && state==RUN): pred_pc = head.pc; pred_update_en=1; pred_update_val=resolve_taken.
  - Otherwise: pred_pc = req_pc; pred_update_en=0.
  - Resolve has strict priority.
- resolve_rdy = (state==RUN) && (count>0).
- req_rdy = (state==RUN) && (count<NUM_INFLIGHT) && !(resolve_val && resolve_rdy).
- resp_taken = pred_prediction when req fires, else 0.
- On req fire: push {req_pc, pred_prediction} at the tail.
- On resolve fire: pop the head. If resolve_taken != head.predicted_taken, set mispredict=1 on the next edge and enter FLUSH.
- Pushes and pops never happen in the same cycle, because arbitration blocks req during a resolve.
- Mispredict path:
  - In the FLUSH cycle, all remaining entries are discarded (count=0, pointers reset to 0).
  - req_rdy=0 and resolve_rdy=0 during FLUSH.
  - mispredict is high exactly during the FLUSH cycle and returns low afterwards.
- Boundaries:
  - Full: req_rdy=0; a resolve still proceeds.
  - Empty: resolve_val is ignored (resolve_rdy=0), and no update is issued.
  - Correct prediction: no flush; mispredict stays 0.
  - Reset asserted mid-FLUSH or with a full FIFO: the next cycle shows the reset values; pending entries are lost.
  - req_val held during a resolve: the request stalls, its data must be held, and it fires on the first non-resolve cycle.

Optional Feature:
- BRANCH_PRED_CTRL_STATS_EN defined: adds outputs stat_resolved[31:0] and stat_mispred[31:0].
  - stat_resolved increments on every resolve fire.
  - stat_mispred increments on every mispredicting resolve.
  - Both clear on reset and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package lab4_branch_pkg holds:
  - typedef inflight_entry_t {logic [PC_W-1:0] pc; logic pred;}
  - enum ctrl_state_t {RUN, FLUSH}
  - constant DEFAULT_NUM_INFLIGHT=4
- Natural sub-module: branch_inflight_fifo. It provides a parameterized push/pop/flush FIFO with count, full and empty outputs. The controller holds arbitration, the FSM and the statistics.

Test Plan:
- After reset, predictor model returns 1; req_pc=0x100 -> req_rdy=1, resp_taken=1, inflight_count=1, pred_update_en=0.
- Fill 4 requests (0x100..0x10C) -> inflight_count=4, req_rdy=0. Then resolve_taken matching each prediction -> pred_pc=0x100,0x104,... in order, pred_update_en=1 each cycle, mispredict stays 0, count returns to 0.
- Simultaneous req_val (pc 0x200) and resolve_val with 1 entry (pc 0x100) -> pred_pc=0x100, req_rdy=0. Next cycle req fires with pred_pc=0x200.
- 3 entries, head predicted 1, resolve_taken=0 -> pred_update_val=0. Next cycle mispredict=1, req_rdy=0, resolve_rdy=0. Following cycle inflight_count=0, mispredict=0, req_rdy=1.
- resolve_val=1 with empty FIFO -> resolve_rdy=0, pred_update_en=0, count unchanged.
- Reset asserted during the FLUSH cycle with stats enabled -> next cycle count=0, mispredict=0, stat_resolved=0, stat_mispred=0.
